// File: rtl/traffic_light_fsm.sv
// Intersection sequencer: edge-detects the 1 Hz level into a seconds tick and
// walks NS/EW lamps through green/yellow/all-red. Optional night flash: NIGHT_FLASH_EN.
//
// state     | meaning
// NS_GREEN  | main road green, resting until a side-road request and min green
// NS_YELLOW | main road yellow
// RED_A     | all-red clearance before EW green
// EW_GREEN  | side road green, fixed length
// EW_YELLOW | side road yellow
// RED_B     | all-red clearance before NS green
// FLASH     | night mode, NS yellow / EW red blinking (NIGHT_FLASH_EN only)
module traffic_light_fsm #(
    parameter int T_NS_GREEN_MIN = 20,
    parameter int T_YELLOW       = 3,
    parameter int T_ALL_RED      = 1,
    parameter int T_EW_GREEN     = 10,
    parameter int CNT_W          = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hz_1_level,
    input  logic       ew_car,
`ifdef NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic [2:0] phase,
    output logic       sec_tick
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
`ifdef NIGHT_FLASH_EN
        FLASH     = 3'd6,
`endif
        RED_B     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] NS_MIN_TC = CNT_W'(T_NS_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_TC    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] RED_TC    = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] EWG_TC    = CNT_W'(T_EW_GREEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic             car_pend;
    logic             hz_1_d;
    logic [2:0]       ns_next;
    logic [2:0]       ew_next;
`ifdef NIGHT_FLASH_EN
    logic             blink;
    logic             blink_next;
`endif

    assign sec_tick = hz_1_level & ~hz_1_d;
    assign phase    = state;

    // hz_1_d keeps tracking the input during reset so release never fakes an edge
    always_ff @(posedge clock) begin
        hz_1_d <= hz_1_level;
        if (reset) begin
            state    <= NS_GREEN;
            timer    <= '0;
            car_pend <= 1'b0;
            ns_lamp  <= 3'b001;
            ew_lamp  <= 3'b100;
`ifdef NIGHT_FLASH_EN
            blink    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state_next != state)
                timer <= '0;
            else if (sec_tick && (timer != '1))
                timer <= timer + CNT_W'(1);
            if ((state_next == EW_GREEN) && (state != EW_GREEN))
                car_pend <= 1'b0;
            else if (ew_car)
                car_pend <= 1'b1;
            ns_lamp <= ns_next;
            ew_lamp <= ew_next;
`ifdef NIGHT_FLASH_EN
            blink   <= blink_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
`ifdef NIGHT_FLASH_EN
        blink_next = blink;
`endif
        case (state)
            NS_GREEN: begin
                if (sec_tick) begin
`ifdef NIGHT_FLASH_EN
                    if (night) begin
                        state_next = FLASH;
                        blink_next = 1'b1;
                    end else
`endif
                    if ((timer >= NS_MIN_TC) && car_pend)
                        state_next = NS_YELLOW;
                end
            end
            NS_YELLOW: if (sec_tick && (timer == YEL_TC)) state_next = RED_A;
            RED_A:     if (sec_tick && (timer == RED_TC)) state_next = EW_GREEN;
            EW_GREEN:  if (sec_tick && (timer == EWG_TC)) state_next = EW_YELLOW;
            EW_YELLOW: if (sec_tick && (timer == YEL_TC)) state_next = RED_B;
            RED_B:     if (sec_tick && (timer == RED_TC)) state_next = NS_GREEN;
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                if (sec_tick) begin
                    if (night)
                        blink_next = ~blink;
                    else
                        state_next = RED_B;
                end
            end
`endif
            default:   state_next = RED_B;
        endcase
    end

    // Lamps are decoded from the next state and registered, so they move on the tick edge
    always_comb begin
        ns_next = 3'b100;
        ew_next = 3'b100;
        case (state_next)
            NS_GREEN:  ns_next = 3'b001;
            NS_YELLOW: ns_next = 3'b010;
            EW_GREEN:  ew_next = 3'b001;
            EW_YELLOW: ew_next = 3'b010;
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                ns_next = blink_next ? 3'b010 : 3'b000;
                ew_next = blink_next ? 3'b100 : 3'b000;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with short phase times; expected
// {phase, ns_lamp, ew_lamp} words go through a scoreboard queue per tick.
module tb_traffic_light_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       hz_1_level = 1'b0;
    logic       ew_car = 1'b0;
    logic       night = 1'b0;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic [2:0] phase;
    logic       sec_tick;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    localparam logic [8:0] S_NSG = {3'd0, 3'b001, 3'b100};
    localparam logic [8:0] S_NSY = {3'd1, 3'b010, 3'b100};
    localparam logic [8:0] S_RA  = {3'd2, 3'b100, 3'b100};
    localparam logic [8:0] S_EWG = {3'd3, 3'b100, 3'b001};
    localparam logic [8:0] S_EWY = {3'd4, 3'b100, 3'b010};
    localparam logic [8:0] S_RB  = {3'd5, 3'b100, 3'b100};
    localparam logic [8:0] S_FL1 = {3'd6, 3'b010, 3'b100};
    localparam logic [8:0] S_FL0 = {3'd6, 3'b000, 3'b000};

    traffic_light_fsm #(
        .T_NS_GREEN_MIN(4),
        .T_YELLOW(2),
        .T_ALL_RED(1),
        .T_EW_GREEN(3),
        .CNT_W(6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hz_1_level(hz_1_level),
        .ew_car(ew_car),
`ifdef NIGHT_FLASH_EN
        .night(night),
`endif
        .ns_lamp(ns_lamp),
        .ew_lamp(ew_lamp),
        .phase(phase),
        .sec_tick(sec_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Never yellow/green on both roads at once
    always @(negedge clock) begin
        if (!reset) begin
            n_checks++;
            assert (!((ns_lamp[1:0] != 2'b00) && (ew_lamp[1:0] != 2'b00))) else begin
                n_fail++;
                $error("FAIL overlap: observed ns=%b ew=%b expected one road red", ns_lamp, ew_lamp);
            end
        end
    end

    // One full 16-clock period of hz_1_level; car=1 raises ew_car during the tick cycle only
    task automatic do_tick(input string tag, input logic [8:0] e, input bit car);
        logic [8:0] got;
        exp_q.push_back(e);
        @(posedge clock); #1;
        hz_1_level = 1'b1;
        if (car) ew_car = 1'b1;
        @(negedge clock);
        check({tag, "_tick_hi"}, {8'd0, sec_tick}, 9'd1);
        @(posedge clock); #1;
        if (car) ew_car = 1'b0;
        @(negedge clock);
        check({tag, "_tick_lo"}, {8'd0, sec_tick}, 9'd0);
        got = exp_q.pop_front();
        check(tag, {phase, ns_lamp, ew_lamp}, got);
        repeat (7) @(posedge clock);
        #1 hz_1_level = 1'b0;
        repeat (8) @(posedge clock);
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
    endtask

    function automatic logic [8:0] exp_cycle(input int k);
        int m;
        if (k < 4) return S_NSG;
        m = (k - 4) % 13;
        if (m <= 1) return S_NSY;
        if (m == 2) return S_RA;
        if (m <= 5) return S_EWG;
        if (m <= 7) return S_EWY;
        if (m == 8) return S_RB;
        return S_NSG;
    endfunction

    initial begin
        // reset while the divider level is already high: no tick on release
        hz_1_level = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("rst_no_tick%0d", i), {8'd0, sec_tick}, 9'd0);
        end
        check("rst_lamps", {phase, ns_lamp, ew_lamp}, S_NSG);
        repeat (5) @(posedge clock);
        #1 hz_1_level = 1'b0;
        repeat (8) @(posedge clock);

        // idle: 64 ticks drive the timer into saturation without any change
        for (int k = 1; k <= 64; k++)
            do_tick($sformatf("idle%0d", k), S_NSG, 1'b0);
        @(posedge clock); #1 ew_car = 1'b1;
        @(posedge clock); #1 ew_car = 1'b0;
        do_tick("sat_yellow", S_NSY, 1'b0);

        // single car pulse at tick 1, full cycle, then request must be gone
        pulse_reset();
        for (int k = 1; k <= 13; k++)
            do_tick($sformatf("pulse%0d", k), exp_cycle(k), k == 1);
        for (int k = 14; k <= 18; k++)
            do_tick($sformatf("cleared%0d", k), S_NSG, 1'b0);

        // car held: request re-latches after EW green entry, 13-tick period
        pulse_reset();
        ew_car = 1'b1;
        for (int k = 1; k <= 30; k++)
            do_tick($sformatf("held%0d", k), exp_cycle(k), 1'b0);
        ew_car = 1'b0;

        // reset for one clock while EW is green
        pulse_reset();
        for (int k = 1; k <= 7; k++)
            do_tick($sformatf("pre_rst%0d", k), exp_cycle(k), k == 1);
        pulse_reset();
        @(negedge clock);
        check("mid_rst", {phase, ns_lamp, ew_lamp}, S_NSG);
        for (int k = 1; k <= 6; k++)
            do_tick($sformatf("post_rst%0d", k), S_NSG, 1'b0);

`ifdef NIGHT_FLASH_EN
        pulse_reset();
        do_tick("fl_pre", S_NSG, 1'b0);
        night = 1'b1;
        do_tick("fl_on1", S_FL1, 1'b0);
        do_tick("fl_off1", S_FL0, 1'b0);
        do_tick("fl_on2", S_FL1, 1'b0);
        do_tick("fl_off2", S_FL0, 1'b0);
        night = 1'b0;
        do_tick("fl_redb", S_RB, 1'b0);
        do_tick("fl_nsg", S_NSG, 1'b0);
`endif

        check("sb_empty", 9'(exp_q.size()), 9'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
